// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding and widths.
package fetch_pkg;

    localparam int FETCH_CNT_W  = 4;
    localparam int FETCH_ADDR_W = 16;
    localparam int FETCH_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR_HI = 3'd1,
        ADDR_LO = 3'd2,
        WAIT    = 3'd3,
        DATA_HI = 3'd4,
        DATA_LO = 3'd5,
        HOLD    = 3'd6
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Core request/response handshake plus the byte-wide external memory bus.
// The slave modport is the fetch unit's view; master is the core/memory side.
interface fetch_unit_if;
    import fetch_pkg::*;

    logic                    req_valid;
    logic [FETCH_ADDR_W-1:0] req_addr;
    logic                    req_ready;
    logic                    flush;
    logic                    instr_valid;
    logic [FETCH_ADDR_W-1:0] instr;
    logic                    instr_ready;
    logic [FETCH_BYTE_W-1:0] bus_out;
    logic [FETCH_BYTE_W-1:0] bus_oe;
    logic [FETCH_BYTE_W-1:0] bus_in;
    logic                    bus_ale;
    logic                    bus_rd;
    logic                    bus_wait;

    modport slave (
        input  req_valid, req_addr, flush, instr_ready, bus_in, bus_wait,
        output req_ready, instr_valid, instr, bus_out, bus_oe, bus_ale, bus_rd
    );

    modport master (
        output req_valid, req_addr, flush, instr_ready, bus_in, bus_wait,
        input  req_ready, instr_valid, instr, bus_out, bus_oe, bus_ale, bus_rd
    );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sends a 16-bit address as two latched bytes, waits a
// fixed number of idle cycles, reads two data bytes (high first) honouring
// bus_wait, then holds the word until the core takes it. flush aborts at once.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.slave  fi
);

    // Value loaded on entry to WAIT so that WAIT lasts exactly LATENCY cycles.
    localparam logic [FETCH_CNT_W-1:0] LAT_M1 =
        (LATENCY > 0) ? FETCH_CNT_W'(LATENCY - 1) : '0;

    fetch_state_t            state_reg, state_next;
    logic [FETCH_ADDR_W-1:0] addr_reg,  addr_next;
    logic [FETCH_ADDR_W-1:0] instr_reg, instr_next;
    logic [FETCH_CNT_W-1:0]  cnt_reg,   cnt_next;

    // State, captured address, instruction word and wait counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            instr_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            instr_reg <= instr_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic; flush wins over every handshake and over bus_wait,
    // and leaves instr untouched so the last word stays visible.
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        instr_next = instr_reg;
        cnt_next   = cnt_reg;
        if (fi.flush) begin
            state_next = IDLE;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (fi.req_valid) begin
                        addr_next  = fi.req_addr;
                        state_next = ADDR_HI;
                    end
                end
                ADDR_HI: state_next = ADDR_LO;
                ADDR_LO: begin
                    if (LATENCY > 0) begin
                        state_next = WAIT;
                        cnt_next   = LAT_M1;
                    end else begin
                        state_next = DATA_HI;
                    end
                end
                WAIT: begin
                    if (cnt_reg == '0) begin
                        state_next = DATA_HI;
                    end else begin
                        cnt_next = cnt_reg - FETCH_CNT_W'(1);
                    end
                end
                DATA_HI: begin
                    if (!fi.bus_wait) begin
                        instr_next[15:8] = fi.bus_in;
                        state_next       = DATA_LO;
                    end
                end
                DATA_LO: begin
                    if (!fi.bus_wait) begin
                        instr_next[7:0] = fi.bus_in;
                        state_next      = HOLD;
                    end
                end
                HOLD: begin
                    if (fi.instr_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Bus and handshake outputs decoded from the current state.
    always_comb begin
        fi.bus_out     = '0;
        fi.bus_oe      = '0;
        fi.bus_ale     = 1'b0;
        fi.bus_rd      = 1'b0;
        fi.instr_valid = 1'b0;
        fi.req_ready   = 1'b0;
        unique case (state_reg)
            IDLE: fi.req_ready = !fi.flush;
            ADDR_HI: begin
                fi.bus_out = addr_reg[15:8];
                fi.bus_oe  = 8'hFF;
                fi.bus_ale = 1'b1;
            end
            ADDR_LO: begin
                fi.bus_out = addr_reg[7:0];
                fi.bus_oe  = 8'hFF;
                fi.bus_ale = 1'b1;
            end
            WAIT, DATA_HI, DATA_LO: fi.bus_rd = 1'b1;
            HOLD: fi.instr_valid = 1'b1;
            default: ;
        endcase
    end

    assign fi.instr = instr_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one DUT with LATENCY=1, one with LATENCY=0.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fetch_unit_if if1 ();
    fetch_unit_if if0 ();

    fetch_unit #(.LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .fi(if1));
    fetch_unit #(.LATENCY(0)) dut0 (.clk(clk), .rst_n(rst_n), .fi(if0));

    // Hard stop in case something hangs outside the bounded loops.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Fetch on the LATENCY=1 unit with no wait states. Returns cycles from
    // the accepting edge to instr_valid (-1 on timeout) and the bus phases.
    task automatic fetch1(input logic [15:0] a, input logic [7:0] hi, input logic [7:0] lo,
                          output int lat, output logic [16:0] ph0, output logic [16:0] ph1,
                          output logic rd2);
        lat = -1; ph0 = '0; ph1 = '0; rd2 = 1'b0;
        if1.req_valid = 1'b1;
        if1.req_addr  = a;
        @(posedge clk); #1;
        if1.req_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k == 3) if1.bus_in = hi;
            if (k == 4) if1.bus_in = lo;
            @(negedge clk);
            if (k == 0) ph0 = {if1.bus_ale, if1.bus_oe, if1.bus_out};
            if (k == 1) ph1 = {if1.bus_ale, if1.bus_oe, if1.bus_out};
            if (k == 2) rd2 = if1.bus_rd;
            if (if1.instr_valid) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        $display("txn fetch addr=%h instr=%h latency=%0d", a, if1.instr, lat);
    endtask

    task automatic test_reset();
        if1.req_valid = 0; if1.req_addr = 0; if1.flush = 0; if1.instr_ready = 0;
        if1.bus_in = 0; if1.bus_wait = 0;
        if0.req_valid = 0; if0.req_addr = 0; if0.flush = 0; if0.instr_ready = 0;
        if0.bus_in = 0; if0.bus_wait = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (if1.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid got %b want 0", if1.instr_valid); end
        checks++; if (if1.bus_oe !== 8'h00) begin errors++; $display("FAIL reset_bus_oe got %h want 00", if1.bus_oe); end
        checks++; if (if1.bus_out !== 8'h00) begin errors++; $display("FAIL reset_bus_out got %h want 00", if1.bus_out); end
        checks++; if (if1.bus_ale !== 1'b0) begin errors++; $display("FAIL reset_bus_ale got %b want 0", if1.bus_ale); end
        checks++; if (if1.bus_rd !== 1'b0) begin errors++; $display("FAIL reset_bus_rd got %b want 0", if1.bus_rd); end
        checks++; if (if1.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", if1.req_ready); end
        checks++; if (if1.instr !== 16'h0000) begin errors++; $display("FAIL reset_instr got %h want 0000", if1.instr); end
        checks++; if (if0.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready_lat0 got %b want 1", if0.req_ready); end
        $display("txn reset done");
    endtask

    task automatic test_basic();
        int lat; logic [16:0] p0, p1; logic rd2;
        fetch1(16'h1234, 8'hAB, 8'hCD, lat, p0, p1, rd2);
        checks++; if (p0 !== {1'b1, 8'hFF, 8'h12}) begin errors++; $display("FAIL basic_addr_hi got %h want %h", p0, {1'b1, 8'hFF, 8'h12}); end
        checks++; if (p1 !== {1'b1, 8'hFF, 8'h34}) begin errors++; $display("FAIL basic_addr_lo got %h want %h", p1, {1'b1, 8'hFF, 8'h34}); end
        checks++; if (rd2 !== 1'b1) begin errors++; $display("FAIL basic_wait_rd got %b want 1", rd2); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency got %0d want 5", lat); end
        checks++; if (if1.instr !== 16'hABCD) begin errors++; $display("FAIL basic_instr got %h want abcd", if1.instr); end
        if1.instr_ready = 1'b1;
        @(posedge clk); #1;
        if1.instr_ready = 1'b0;
        @(negedge clk);
        checks++; if (if1.req_ready !== 1'b1) begin errors++; $display("FAIL basic_back_idle got %b want 1", if1.req_ready); end
        checks++; if (if1.instr_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b want 0", if1.instr_valid); end
    endtask

    task automatic test_wait_lo();
        int lat; logic rd_ok;
        lat = -1; rd_ok = 1'b1;
        if0.req_valid = 1'b1;
        if0.req_addr  = 16'h5678;
        @(posedge clk); #1;
        if0.req_valid = 1'b0;
        for (int k = 0; k < 30; k++) begin
            case (k)
                2: if0.bus_in = 8'h11;
                3: begin if0.bus_wait = 1'b1; if0.bus_in = 8'hEE; end
                6: begin if0.bus_wait = 1'b0; if0.bus_in = 8'h22; end
                default: ;
            endcase
            @(negedge clk);
            if (k >= 2 && k <= 6 && if0.bus_rd !== 1'b1) rd_ok = 1'b0;
            if (if0.instr_valid) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        if0.bus_wait = 1'b0;
        $display("txn fetch_wait addr=5678 instr=%h latency=%0d", if0.instr, lat);
        checks++; if (lat !== 7) begin errors++; $display("FAIL wait_latency got %0d want 7", lat); end
        checks++; if (if0.instr !== 16'h1122) begin errors++; $display("FAIL wait_instr got %h want 1122", if0.instr); end
        checks++; if (rd_ok !== 1'b1) begin errors++; $display("FAIL wait_bus_rd got %b want 1", rd_ok); end
        if0.instr_ready = 1'b1;
        @(posedge clk); #1;
        if0.instr_ready = 1'b0;
        @(negedge clk);
        checks++; if (if0.req_ready !== 1'b1) begin errors++; $display("FAIL wait_back_idle got %b want 1", if0.req_ready); end
    endtask

    task automatic test_hold_stall();
        int lat; logic [16:0] p0, p1; logic rd2;
        fetch1(16'h0102, 8'h5A, 8'hA5, lat, p0, p1, rd2);
        checks++; if (lat !== 5) begin errors++; $display("FAIL stall_latency got %0d want 5", lat); end
        if1.instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++; if (if1.instr !== 16'h5AA5) begin errors++; $display("FAIL stall_instr cycle %0d got %h want 5aa5", i, if1.instr); end
            checks++; if (if1.req_ready !== 1'b0) begin errors++; $display("FAIL stall_req_ready cycle %0d got %b want 0", i, if1.req_ready); end
            checks++; if (if1.instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid cycle %0d got %b want 1", i, if1.instr_valid); end
        end
        if1.instr_ready = 1'b1;
        @(posedge clk); #1;
        if1.instr_ready = 1'b0;
        @(negedge clk);
        checks++; if (if1.req_ready !== 1'b1) begin errors++; $display("FAIL stall_accept_idle got %b want 1", if1.req_ready); end
    endtask

    // Flush after kt cycles past acceptance: 1=ADDR_LO, 2=WAIT, 3=DATA_HI.
    task automatic test_flush_at(input int kt);
        if1.req_valid = 1'b1;
        if1.req_addr  = 16'h0777;
        @(posedge clk); #1;
        if1.req_valid = 1'b0;
        repeat (kt) begin @(posedge clk); #1; end
        if1.flush = 1'b1;
        @(posedge clk); #1;
        if1.flush = 1'b0;
        @(negedge clk);
        checks++; if (if1.instr_valid !== 1'b0) begin errors++; $display("FAIL flush%0d_valid got %b want 0", kt, if1.instr_valid); end
        checks++; if (if1.bus_oe !== 8'h00) begin errors++; $display("FAIL flush%0d_bus_oe got %h want 00", kt, if1.bus_oe); end
        checks++; if (if1.req_ready !== 1'b1) begin errors++; $display("FAIL flush%0d_idle got %b want 1", kt, if1.req_ready); end
        checks++; if (if1.bus_rd !== 1'b0) begin errors++; $display("FAIL flush%0d_bus_rd got %b want 0", kt, if1.bus_rd); end
        $display("txn flush after %0d cycles", kt);
    endtask

    task automatic test_flush();
        int lat; logic [16:0] p0, p1; logic rd2;
        for (int kt = 1; kt <= 3; kt++) test_flush_at(kt);
        fetch1(16'h0B0B, 8'h3C, 8'hC3, lat, p0, p1, rd2);
        if1.flush = 1'b1;
        if1.instr_ready = 1'b1;
        @(posedge clk); #1;
        if1.flush = 1'b0;
        if1.instr_ready = 1'b0;
        @(negedge clk);
        checks++; if (if1.instr_valid !== 1'b0) begin errors++; $display("FAIL flush_hold_valid got %b want 0", if1.instr_valid); end
        checks++; if (if1.req_ready !== 1'b1) begin errors++; $display("FAIL flush_hold_idle got %b want 1", if1.req_ready); end
        checks++; if (if1.instr !== 16'h3CC3) begin errors++; $display("FAIL flush_hold_instr_kept got %h want 3cc3", if1.instr); end
        fetch1(16'h0040, 8'h9F, 8'hF9, lat, p0, p1, rd2);
        checks++; if (p0 !== {1'b1, 8'hFF, 8'h00}) begin errors++; $display("FAIL refetch_addr_hi got %h want %h", p0, {1'b1, 8'hFF, 8'h00}); end
        checks++; if (p1 !== {1'b1, 8'hFF, 8'h40}) begin errors++; $display("FAIL refetch_addr_lo got %h want %h", p1, {1'b1, 8'hFF, 8'h40}); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL refetch_latency got %0d want 5", lat); end
        checks++; if (if1.instr !== 16'h9FF9) begin errors++; $display("FAIL refetch_instr got %h want 9ff9", if1.instr); end
        if1.instr_ready = 1'b1;
        @(posedge clk); #1;
        if1.instr_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic pulse;
        pulse = 1'b0;
        if1.req_valid = 1'b1;
        if1.req_addr  = 16'h2468;
        @(posedge clk); #1;
        if1.req_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (if1.instr_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", if1.instr_valid); end
        checks++; if (if1.bus_oe !== 8'h00) begin errors++; $display("FAIL rstmid_bus_oe got %h want 00", if1.bus_oe); end
        checks++; if (if1.bus_out !== 8'h00) begin errors++; $display("FAIL rstmid_bus_out got %h want 00", if1.bus_out); end
        checks++; if (if1.bus_ale !== 1'b0) begin errors++; $display("FAIL rstmid_bus_ale got %b want 0", if1.bus_ale); end
        checks++; if (if1.bus_rd !== 1'b0) begin errors++; $display("FAIL rstmid_bus_rd got %b want 0", if1.bus_rd); end
        checks++; if (if1.req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_req_ready got %b want 1", if1.req_ready); end
        checks++; if (if1.instr !== 16'h0000) begin errors++; $display("FAIL rstmid_instr got %h want 0000", if1.instr); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (if1.instr_valid !== 1'b0) pulse = 1'b1;
        end
        checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL rstmid_no_pulse got %b want 0", pulse); end
        $display("txn reset during DATA_HI");
    endtask

    task automatic test_flush_idle();
        if1.flush = 1'b1;
        if1.req_valid = 1'b1;
        if1.req_addr = 16'h9999;
        @(negedge clk);
        checks++; if (if1.req_ready !== 1'b0) begin errors++; $display("FAIL flushidle_req_ready got %b want 0", if1.req_ready); end
        @(posedge clk); #1;
        if1.flush = 1'b0;
        if1.req_valid = 1'b0;
        @(negedge clk);
        checks++; if (if1.req_ready !== 1'b1) begin errors++; $display("FAIL flushidle_still_idle got %b want 1", if1.req_ready); end
        checks++; if (if1.bus_ale !== 1'b0) begin errors++; $display("FAIL flushidle_no_addr got %b want 0", if1.bus_ale); end
        @(negedge clk);
        checks++; if (if1.bus_ale !== 1'b0) begin errors++; $display("FAIL flushidle_no_addr2 got %b want 0", if1.bus_ale); end
        $display("txn flush+req in IDLE");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_lo();
        test_hold_stall();
        test_flush();
        test_reset_mid();
        test_flush_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter LATENCY, default 1, giving the idle bus cycles between the low address byte and the first data byte (legal range 0..15).
REQ-002 SHALL have port clk  in  1  clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  in  1  core requests a fetch.
REQ-005 SHALL have port req_addr  in  16  fetch word address (core PC).
REQ-006 SHALL have port req_ready  out  1  unit accepts a request.
REQ-007 SHALL have port flush  in  1  abandon the in-flight fetch (branch/jump redirect).
REQ-008 SHALL have port instr_valid  out  1  instr holds a fetched word.
REQ-009 SHALL have port instr  out  16  fetched instruction, high byte first on the bus.
REQ-010 SHALL have port instr_ready  in  1  core consumes instr.
REQ-011 SHALL have port bus_out  out  8  address byte to external memory.
REQ-012 SHALL have port bus_oe  out  8  pad output enables, 1 = drive.
REQ-013 SHALL have port bus_in  in  8  data byte from external memory.
REQ-014 SHALL have port bus_ale  out  1  address latch enable.
REQ-015 SHALL have port bus_rd  out  1  read strobe.
REQ-016 SHALL have port bus_wait  in  1  memory not ready; stalls the data phases.

Function
REQ-017 SHALL implement FSM states IDLE, ADDR_HI, ADDR_LO, WAIT, DATA_HI, DATA_LO, HOLD.
REQ-018 SHALL assert req_ready only in IDLE with flush low; on req_valid&&req_ready it captures req_addr and moves to ADDR_HI.
REQ-019 SHALL drive bus_out=addr[15:8], bus_oe=8'hFF, bus_ale=1 in ADDR_HI, then addr[7:0] likewise in ADDR_LO; bus_out=0, bus_oe=0, bus_ale=0 in all other states.
REQ-020 SHALL go from ADDR_LO to WAIT when LATENCY>0 (stay LATENCY cycles, 4-bit down-counter), else directly to DATA_HI.
REQ-021 SHALL assert bus_rd in WAIT, DATA_HI, DATA_LO only.
REQ-022 SHALL, in DATA_HI with bus_wait low, capture bus_in into instr[15:8] and advance; DATA_LO likewise into instr[7:0] and advance to HOLD.
REQ-023 SHALL hold state and the instr bytes while bus_wait is high in DATA_HI/DATA_LO; bus_wait SHALL be ignored in other states.
REQ-024 SHALL assert instr_valid only in HOLD, with instr stable until the handshake.
REQ-025 SHALL return to IDLE on instr_valid&&instr_ready; with no wait states, instr_valid SHALL first rise 4+LATENCY cycles after the accepting edge.
REQ-026 SHALL, on flush high in any state, enter IDLE at the next edge, dropping instr_valid and bus_oe; flush overrides bus_wait, req_valid and instr_ready in the same cycle.
REQ-027 SHALL leave instr holding its last value after a flush; only instr_valid marks it usable.

Reset
REQ-028 SHALL, at an edge with rst_n low, set state=IDLE, captured address=0, instr=16'h0000 and the wait counter to 0.
REQ-029 SHALL, after reset, present instr_valid=0, bus_oe=0, bus_out=0, bus_ale=0, bus_rd=0, req_ready=1.
REQ-030 SHALL give rst_n priority over flush and all handshakes, aborting any in-flight fetch.

Structure
REQ-031 SHALL take the state encoding and the counter width constant FETCH_CNT_W=4 from shared package fetch_pkg.
REQ-032 SHALL be a single module with no sub-modules; the counter and FSM are inline.

Verification
REQ-033 Bench SHALL check: LATENCY=1, req_addr=16'h1234 -> bus_out 8'h12 then 8'h34 with bus_ale, bus_in 8'hAB,8'hCD -> instr=16'hABCD valid 5 cycles after acceptance.
REQ-034 Bench SHALL check: LATENCY=0, bus_wait high 3 cycles in DATA_LO -> instr_valid delayed exactly 3 cycles and the byte sampled after wait drops.
REQ-035 Bench SHALL check: instr_ready low 4 cycles in HOLD -> instr stable and req_ready low throughout; acceptance returns the unit to IDLE with req_ready=1.
REQ-036 Bench SHALL check: flush asserted in ADDR_LO, WAIT, DATA_HI and HOLD -> next cycle IDLE, instr_valid=0, bus_oe=0; new request 16'h0040 then fetched correctly.
REQ-037 Bench SHALL check: rst_n low in DATA_HI -> all REQ-029 values after the edge; no instr_valid pulse.
REQ-038 Bench SHALL check: flush and req_valid both high in IDLE -> request not accepted (req_ready=0), state stays IDLE.
